data_sampling_mv: RTL and testbench

Parametrised oversampling bit recovery for the UART RX path. Captures RX_IN at a run-time-selectable number of samples (1, 3 or 5) centred on the bit middle and majority-votes them. Outputs the recovered bit, a one-cycle valid strobe and a noise flag. Sits between the RX edge/bit counter and the RX FSM/deserializer, parity and stop checkers.

---
 rtl/uart_rx_pkg.sv | 32 +++
 rtl/data_sampling_mv_if.sv | 35 +++
 rtl/majority_vote.sv | 18 +
 rtl/data_sampling_mv.sv | 163 ++++++++++++++++
 tb/tb_data_sampling_mv.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: sample-count encodings,
// the sampler state type and the smallest usable oversampling ratio.
package uart_rx_pkg;

  // Encoding of the run-time vote size selector.
  typedef enum logic [1:0] {
    SAMP_1    = 2'd0,
    SAMP_3    = 2'd1,
    SAMP_5    = 2'd2,
    SAMP_RSVD = 2'd3
  } samp_mode_e;

  // Sampler state: waiting for a window start, or collecting samples.
  typedef enum logic {
    IDLE = 1'b0,
    WIN  = 1'b1
  } samp_state_e;

  // Below this ratio there is no room for a centred window at all.
  localparam int MIN_PRESCALE = 4;

  // Number of samples requested by a samp_mode value; the reserved code
  // behaves like single sampling.
  function automatic logic [2:0] mode_votes(input logic [1:0] mode);
    case (mode)
      SAMP_3:  mode_votes = 3'd3;
      SAMP_5:  mode_votes = 3'd5;
      default: mode_votes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/data_sampling_mv_if.sv
// Bundle of the sampler's configuration, line and result signals.
//
// Result strobe semantics: sample_valid is a one-cycle pulse with no
// back-pressure (there is no ready). In the cycle it is high, sampled_bit
// and sample_noise carry the new vote; both then hold until the next pulse.
// cfg_err is a registered level, not a strobe.
interface data_sampling_mv_if #(
  parameter int PRESC_W = 6
);
  import uart_rx_pkg::*;

  logic [PRESC_W-1:0] Prescale;
  logic               RX_IN;
  logic               data_samp_en;
  logic [PRESC_W-1:0] edge_cnt;
  logic [1:0]         samp_mode;
  logic               sampled_bit;
  logic               sample_valid;
  logic               sample_noise;
  logic               cfg_err;
  samp_state_e        dbg_state;

  // Driver side: RX edge/bit counter and RX FSM.
  modport master (
    output Prescale, RX_IN, data_samp_en, edge_cnt, samp_mode,
    input  sampled_bit, sample_valid, sample_noise, cfg_err, dbg_state
  );

  // Sampler side.
  modport slave (
    input  Prescale, RX_IN, data_samp_en, edge_cnt, samp_mode,
    output sampled_bit, sample_valid, sample_noise, cfg_err, dbg_state
  );

endinterface

// File: rtl/majority_vote.sv
// Combinational majority decision over an odd number of collected samples.
// Reports the winning value and whether the samples disagreed.
module majority_vote #(
  parameter int CNT_W = 3
) (
  input  logic [CNT_W-1:0] ones_i,
  input  logic [CNT_W-1:0] scnt_i,
  output logic             bit_o,
  output logic             noise_o
);

  // Majority wins; any mix of ones and zeros counts as noise.
  always_comb begin
    bit_o   = ones_i > (scnt_i >> 1);
    noise_o = (ones_i != '0) && (ones_i != scnt_i);
  end

endmodule

// File: rtl/data_sampling_mv.sv
// Oversampling bit recovery: collects 1, 3 or 5 samples centred on the bit
// middle and majority-votes them. Window geometry is derived from Prescale
// and samp_mode at the window start and frozen for the rest of the window.
module data_sampling_mv
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W     = 6,
  parameter int MAX_SAMPLES = 5,
  parameter int CNT_W       = 3
) (
  input logic               CLK,
  input logic               RST,
  data_sampling_mv_if.slave bus
);

  localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);
  localparam logic [CNT_W-1:0]   MAX_S = CNT_W'(MAX_SAMPLES);

  // Window arithmetic, evaluated every cycle from the live configuration.
  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] h_req;
  logic [PRESC_W-1:0] h_eff;
  logic [PRESC_W-1:0] win_start;
  logic [PRESC_W-1:0] vote_pt;
  logic [CNT_W-1:0]   n_req;
  logic               presc_small;
  logic               req_ok;

  // State and counters.
  samp_state_e        state_q, state_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;
  logic [CNT_W-1:0]   ones_q, ones_d;
  logic [PRESC_W-1:0] start_q, start_d;
  logic [PRESC_W-1:0] vote_q, vote_d;

  // Registered results.
  logic sampled_bit_q, sampled_bit_d;
  logic sample_noise_q, sample_noise_d;
  logic sample_valid_q, sample_valid_d;
  logic cfg_err_q, cfg_err_d;

  // Vote outcome for the samples collected so far.
  logic vote_bit;
  logic vote_noise;

  majority_vote #(
    .CNT_W(CNT_W)
  ) u_vote (
    .ones_i (ones_q),
    .scnt_i (scnt_q),
    .bit_o  (vote_bit),
    .noise_o(vote_noise)
  );

  // Centre c = half-1, window [c-h, c+h], vote point c+h+1. An illegal
  // request (too wide for the bit, or more samples than supported) falls
  // back to a single sample at the centre.
  always_comb begin
    half        = bus.Prescale >> 1;
    presc_small = bus.Prescale < PRESC_W'(MIN_PRESCALE);
    n_req       = CNT_W'(mode_votes(bus.samp_mode));
    h_req       = PRESC_W'(mode_votes(bus.samp_mode) >> 1);
    req_ok      = (n_req <= MAX_S) &&
                  (half >= h_req + P_ONE) &&
                  ((half + h_req + P_ONE) <= bus.Prescale);
    h_eff       = req_ok ? h_req : '0;
    win_start   = half - P_ONE - h_eff;
    vote_pt     = half + h_eff;
  end

  // Next-state logic: window entry, sample accumulation, vote and aborts.
  always_comb begin
    state_d        = state_q;
    scnt_d         = scnt_q;
    ones_d         = ones_q;
    start_d        = start_q;
    vote_d         = vote_q;
    sampled_bit_d  = sampled_bit_q;
    sample_noise_d = sample_noise_q;
    sample_valid_d = 1'b0;
    cfg_err_d      = cfg_err_q;

    if (presc_small) begin
      cfg_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Only a window entered exactly at its start is ever voted, so a
        // late enable waits for the next bit rather than voting partially.
        if (bus.data_samp_en && !presc_small && (bus.edge_cnt == win_start)) begin
          state_d   = WIN;
          scnt_d    = CNT_W'(1);
          ones_d    = CNT_W'(bus.RX_IN);
          start_d   = win_start;
          vote_d    = vote_pt;
          cfg_err_d = !req_ok;
        end else begin
          scnt_d = '0;
          ones_d = '0;
        end
      end
      WIN: begin
        if (!bus.data_samp_en || presc_small) begin
          state_d = IDLE;
          scnt_d  = '0;
          ones_d  = '0;
        end else if (bus.edge_cnt == vote_q) begin
          state_d        = IDLE;
          sampled_bit_d  = vote_bit;
          sample_noise_d = vote_noise;
          sample_valid_d = 1'b1;
        end else if ((bus.edge_cnt > start_q) && (bus.edge_cnt < vote_q)) begin
          scnt_d = scnt_q + CNT_W'(1);
          ones_d = ones_q + CNT_W'(bus.RX_IN);
        end else begin
          // edge_cnt left the window without hitting the vote point
          // (wrap after an illegal Prescale change): drop the window.
          state_d = IDLE;
          scnt_d  = '0;
          ones_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        scnt_d  = '0;
        ones_d  = '0;
      end
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      scnt_q         <= '0;
      ones_q         <= '0;
      start_q        <= '0;
      vote_q         <= '0;
      sampled_bit_q  <= 1'b0;
      sample_noise_q <= 1'b0;
      sample_valid_q <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      scnt_q         <= scnt_d;
      ones_q         <= ones_d;
      start_q        <= start_d;
      vote_q         <= vote_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_noise_q <= sample_noise_d;
      sample_valid_q <= sample_valid_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.sample_noise = sample_noise_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_data_sampling_mv.sv
// Bench for data_sampling_mv: directed bit periods followed by random ones,
// each checked cycle by cycle against a per-bit window model.
module tb_data_sampling_mv;

  localparam int PW = 6;

  // Clock and reset.
  logic CLK;
  logic RST;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  data_sampling_mv_if #(.PRESC_W(PW)) bus ();

  data_sampling_mv #(
    .PRESC_W    (PW),
    .MAX_SAMPLES(5),
    .CNT_W      (3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Scoreboard state.
  int         total = 0;
  int         bad   = 0;
  logic [1:0] exp_q[$];
  logic       exp_bit;
  logic       exp_noise;
  logic       exp_cfg;
  logic       exp_pulse;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Window geometry straight from the centre/half-width formulas.
  function automatic void win_of(input int p, input int mode,
                                 output int s, output int v, output bit ok);
    int c, n, h;
    c  = p / 2 - 1;
    n  = (mode == 1) ? 3 : (mode == 2) ? 5 : 1;
    h  = (n - 1) / 2;
    ok = (c >= h) && (c + h + 1 <= p - 1) && (n <= 5);
    if (!ok) h = 0;
    s = c - h;
    v = c + h + 1;
  endfunction

  // Drives one bit period (edge_cnt 0..p-1) and checks every cycle.
  // chg_at/chg_mode switch samp_mode mid-bit (used only after the window
  // start); rst_at pulses RST low for one cycle at that edge_cnt.
  task automatic drive_bit(input int p, input int mode,
                           input logic [63:0] rx, input logic [63:0] en,
                           input int chg_at, input int chg_mode, input int rst_at);
    int s, v, ones;
    bit ok, alive;
    logic [1:0] got;
    win_of(p, mode, s, v, ok);
    alive = 0;
    for (int e = 0; e < p; e++) begin
      bus.Prescale     = PW'(p);
      bus.edge_cnt     = PW'(e);
      bus.RX_IN        = rx[e];
      bus.data_samp_en = en[e];
      bus.samp_mode    = (chg_at >= 0 && e >= chg_at) ? 2'(chg_mode) : 2'(mode);
      exp_pulse = 1'b0;
      if (e == rst_at) begin
        RST = 1'b0;
        #1;
        chk("rst_bit",   bus.sampled_bit,  1'b0);
        chk("rst_noise", bus.sample_noise, 1'b0);
        chk("rst_valid", bus.sample_valid, 1'b0);
        chk("rst_cfg",   bus.cfg_err,      1'b0);
        exp_bit = 1'b0; exp_noise = 1'b0; exp_cfg = 1'b0; alive = 0;
      end else if (p < 4) begin
        exp_cfg = 1'b1;
      end else begin
        if (e == s && en[e]) begin
          alive   = 1;
          exp_cfg = !ok;
        end else if (alive && !en[e]) begin
          alive = 0;
        end
        if (alive && e == v) begin
          ones = 0;
          for (int k = s; k < v; k++) ones += int'(rx[k]);
          exp_bit   = (2 * ones > (v - s));
          exp_noise = (ones != 0) && (ones != (v - s));
          exp_q.push_back({exp_bit, exp_noise});
          exp_pulse = 1'b1;
          alive     = 0;
        end
      end
      @(posedge CLK);
      #1;
      if (e == rst_at) RST = 1'b1;
      chk("valid", bus.sample_valid, exp_pulse);
      chk("bit",   bus.sampled_bit,  exp_bit);
      chk("noise", bus.sample_noise, exp_noise);
      chk("cfg",   bus.cfg_err,      exp_cfg);
      if (bus.sample_valid === 1'b1 && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("vote_bit",   bus.sampled_bit,  got[1]);
        chk("vote_noise", bus.sample_noise, got[0]);
      end
    end
  endtask

  initial begin
    RST              = 1'b1;
    bus.Prescale     = PW'(8);
    bus.edge_cnt     = '0;
    bus.RX_IN        = 1'b0;
    bus.data_samp_en = 1'b0;
    bus.samp_mode    = 2'd0;
    exp_bit = 1'b0; exp_noise = 1'b0; exp_cfg = 1'b0; exp_pulse = 1'b0;

    // Reset state.
    #1 RST = 1'b0;
    #1;
    chk("reset_bit",   bus.sampled_bit,  1'b0);
    chk("reset_noise", bus.sample_noise, 1'b0);
    chk("reset_valid", bus.sample_valid, 1'b0);
    chk("reset_cfg",   bus.cfg_err,      1'b0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;

    // Prescale 8, 3 samples at 2..4 = 1,0,1: bit 1 with noise.
    drive_bit(8, 1, 64'h14, '1, -1, 0, -1);
    // Prescale 16, 5 samples at 5..9 = 0,0,1,0,0, then an all-ones bit.
    drive_bit(16, 2, 64'h80, '1, -1, 0, -1);
    drive_bit(16, 2, 64'hFFFF, '1, -1, 0, -1);
    // Prescale 4 cannot hold 5 samples: fallback to one sample at edge 1.
    drive_bit(4, 2, 64'h2, '1, -1, 0, -1);
    // Enable drops at edge 3, comes back at edge 3 of the next bit.
    drive_bit(8, 1, 64'h0, 64'h07, -1, 0, -1);
    drive_bit(8, 1, 64'h0, 64'hF8, -1, 0, -1);
    drive_bit(8, 1, 64'h0, '1, -1, 0, -1);
    // Reset mid-window with sampled_bit=1.
    drive_bit(8, 1, '1, '1, -1, 0, -1);
    drive_bit(8, 1, '1, '1, -1, 0, 3);
    // Mode change 1->2 at edge 3: still a 3-sample vote over 2..4.
    drive_bit(8, 1, 64'h0C, '1, 3, 2, -1);
    // Prescale too small: no pulses, cfg_err set.
    for (int i = 0; i < 4; i++) drive_bit(2, i, {$urandom, $urandom}, '1, -1, 0, -1);
    drive_bit(3, 1, {$urandom, $urandom}, '1, -1, 0, -1);

    // Random bit periods, occasionally with an enable glitch.
    for (int i = 0; i < 40; i++) begin
      int p, m;
      logic [63:0] en;
      p  = $urandom_range(4, 24);
      m  = $urandom_range(0, 3);
      en = '1;
      if ($urandom_range(0, 3) == 0) en[$urandom_range(0, p - 1)] = 1'b0;
      drive_bit(p, m, {$urandom, $urandom}, en, -1, 0, -1);
    end

    chk("votes_drained", exp_q.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
